// File: rtl/pwm_fb_pkg.sv
// Shared constants, pixel type and helpers for the double-buffered PWM frame store.
package pwm_fb_pkg;

  localparam int unsigned PANEL_W       = 64;
  localparam int unsigned PANEL_H       = 64;
  localparam int unsigned ROW_ADDR_BITS = 5;
  localparam int unsigned COL_BITS      = 6;
  localparam int unsigned PIX_ADDR_BITS = 12;
  localparam int unsigned MAX_CHAN_BITS = 8;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } rgb444_t;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  // Reverses the low n bits of v; bits at or above n come back as zero.
  function automatic logic [MAX_CHAN_BITS-1:0] bitrev(input logic [MAX_CHAN_BITS-1:0] v,
                                                      input int unsigned n);
    logic [MAX_CHAN_BITS-1:0] r;
    logic [2:0]               j;
    r = '0;
    for (int unsigned i = 0; i < MAX_CHAN_BITS; i++) begin
      if (i < n) begin
        j         = 3'(n - 1 - i);
        r[3'(i)]  = v[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_framebuffer_bank.sv
// One frame bank: 4096-word simple dual-port RAM with registered reads on two ports.
module fb_bank #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned ADDR_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr0,
  input  logic [ADDR_BITS-1:0] rd_addr1,
  output logic [WIDTH-1:0]     rd_data0,
  output logic [WIDTH-1:0]     rd_data1
);

  // Two identical copies so each read port maps onto its own block RAM.
  logic [WIDTH-1:0] mem0 [2**ADDR_BITS];
  logic [WIDTH-1:0] mem1 [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem0[wr_addr] <= wr_data;
    end
    rd_data0 <= mem0[rd_addr0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem1[wr_addr] <= wr_data;
    end
    rd_data1 <= mem1[rd_addr1];
  end

endmodule

// File: rtl/pwm_framebuffer.sv
// Double-buffered RGB frame store feeding the LED panel with bit-reversed PWM, 2-clock read latency.
module pwm_framebuffer
  import pwm_fb_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned SUB_BITS   = 8,
  parameter int unsigned CHAN_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FRAME_BITS-1:0]  frame,
  input  logic [SUB_BITS-1:0]    subframe,
  input  logic [4:0]             addr,
  input  logic [5:0]             x,
  output logic [5:0]             rgb,
  input  logic                   wr_en,
  input  logic [11:0]            wr_addr,
  input  logic [3*CHAN_BITS-1:0] wr_data,
  input  logic                   swap_req,
  output logic                   swap_done
);

  localparam int unsigned WORD_BITS = 3 * CHAN_BITS;

  swap_state_t           state;
  logic                  disp_sel;
  logic [FRAME_BITS-1:0] frame_q;
  logic                  boundary;
  logic                  swap_now;
  logic                  sel_eff;

  assign boundary = (frame != frame_q);
  assign swap_now = (state == SWAP_PENDING) && boundary;
  // The swap is visible to reads in the boundary cycle itself, ahead of the disp_sel update.
  assign sel_eff  = disp_sel ^ swap_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SWAP_IDLE;
      disp_sel  <= 1'b0;
      frame_q   <= '0;
      swap_done <= 1'b0;
    end else begin
      frame_q   <= frame;
      swap_done <= swap_now;
      case (state)
        SWAP_IDLE: begin
          if (swap_req) begin
            state <= SWAP_PENDING;
          end
        end
        SWAP_PENDING: begin
          if (boundary) begin
            state    <= SWAP_IDLE;
            disp_sel <= ~disp_sel;
          end
        end
        default: state <= SWAP_IDLE;
      endcase
    end
  end

  logic [PIX_ADDR_BITS-1:0] rd_addr0;
  logic [PIX_ADDR_BITS-1:0] rd_addr1;
  logic [WORD_BITS-1:0]     b0_d0, b0_d1, b1_d0, b1_d1;
  logic                     b0_we, b1_we;

  assign rd_addr0 = {1'b0, addr, x};
  assign rd_addr1 = {1'b1, addr, x};
  assign b0_we    = wr_en & sel_eff;
  assign b1_we    = wr_en & ~sel_eff;

  fb_bank #(
    .WIDTH     (WORD_BITS),
    .ADDR_BITS (PIX_ADDR_BITS)
  ) u_bank0 (
    .clk      (clk),
    .wr_en    (b0_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (b0_d0),
    .rd_data1 (b0_d1)
  );

  fb_bank #(
    .WIDTH     (WORD_BITS),
    .ADDR_BITS (PIX_ADDR_BITS)
  ) u_bank1 (
    .clk      (clk),
    .wr_en    (b1_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (b1_d0),
    .rd_data1 (b1_d1)
  );

  logic                 sel_q;
  logic                 valid_q;
  logic [CHAN_BITS-1:0] sub_q;
  logic                 unused_sub;

  assign unused_sub = ^subframe;

  // valid_q keeps stale RAM words read during reset from reaching rgb.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      sub_q   <= '0;
    end else begin
      sel_q   <= sel_eff;
      valid_q <= 1'b1;
      sub_q   <= subframe[CHAN_BITS-1:0];
    end
  end

  logic [WORD_BITS-1:0]     word0, word1;
  logic [MAX_CHAN_BITS-1:0] thr_full;
  logic [CHAN_BITS-1:0]     thr;
  logic [2:0]               lit0, lit1;

  always_comb begin
    word0    = sel_q ? b1_d0 : b0_d0;
    word1    = sel_q ? b1_d1 : b0_d1;
    thr_full = bitrev(MAX_CHAN_BITS'(sub_q), CHAN_BITS);
    thr      = thr_full[CHAN_BITS-1:0];
    lit0     = '0;
    lit1     = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      lit0[c] = (word0[c*CHAN_BITS +: CHAN_BITS] > thr);
      lit1[c] = (word1[c*CHAN_BITS +: CHAN_BITS] > thr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= '0;
    end else begin
      rgb <= valid_q ? {lit1, lit0} : '0;
    end
  end

endmodule

// File: tb/tb_pwm_framebuffer.sv
// Scoreboard bench for pwm_framebuffer: stimulus queues expected rgb/swap_done per cycle, a monitor checks them.
module tb_pwm_framebuffer;
  import pwm_fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  frame;
  logic [7:0]  subframe;
  logic [4:0]  addr;
  logic [5:0]  x;
  logic [5:0]  rgb;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [11:0] wr_data;
  logic        swap_req;
  logic        swap_done;

  pwm_framebuffer #(
    .FRAME_BITS (10),
    .SUB_BITS   (8),
    .CHAN_BITS  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame     (frame),
    .subframe  (subframe),
    .addr      (addr),
    .x         (x),
    .rgb       (rgb),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .swap_req  (swap_req),
    .swap_done (swap_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          is_swap;
    logic [5:0]  exp;
    logic [63:0] name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].at <= cyc) begin
        checks++;
        if (q[i].at != cyc) begin
          errors++;
          $display("FAIL %0s: slot for cycle %0d reached at cycle %0d", q[i].name, q[i].at, cyc);
        end else if (q[i].is_swap) begin
          if (swap_done !== q[i].exp[0]) begin
            errors++;
            $display("FAIL %0s cycle %0d: swap_done got %b want %b", q[i].name, cyc, swap_done, q[i].exp[0]);
          end
        end else if (rgb !== q[i].exp) begin
          errors++;
          $display("FAIL %0s cycle %0d: rgb got %b want %b", q[i].name, cyc, rgb, q[i].exp);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rgb(input int at, input logic [5:0] e, input logic [63:0] nm);
    q.push_back('{at: at, is_swap: 1'b0, exp: e, name: nm});
  endtask

  task automatic exp_swap(input int at, input logic e, input logic [63:0] nm);
    q.push_back('{at: at, is_swap: 1'b1, exp: {5'b0, e}, name: nm});
  endtask

  // Present one read this cycle; its result is due two cycles later.
  task automatic rd(input logic [4:0] a, input logic [5:0] xx, input logic [7:0] s,
                    input logic [5:0] e, input logic [63:0] nm);
    addr     = a;
    x        = xx;
    subframe = s;
    exp_rgb(cyc + 2, e, nm);
    step();
  endtask

  task automatic wr(input logic [5:0] y, input logic [5:0] xx, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_addr = {y, xx};
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  // Value 8: lit only where bitrev(s) < 8, i.e. even subframes.
  logic [15:0] red8_tab = 16'h5555;
  rgb444_t     pix;

  initial begin
    reset    = 1'b1;
    frame    = '0;
    subframe = '0;
    addr     = '0;
    x        = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    swap_req = 1'b0;

    step();
    step();
    exp_rgb(cyc, 6'b0, "rst_rgb");
    exp_swap(cyc, 1'b0, "rst_swp");
    step();
    reset = 1'b0;

    for (int s = 0; s < 6; s++) begin
      exp_swap(cyc + 1, 1'b0, "t1_swp");
      rd(5'd3, 6'd5, 8'(s), 6'b0, "t1_idle");
    end

    pix = '{b: 4'hF, g: 4'h0, r: 4'h0};
    wr(6'd3, 6'd5, pix);
    wr(6'd35, 6'd5, 12'h000);
    wr(6'd3, 6'd4, 12'h000);
    wr(6'd35, 6'd4, 12'h000);
    wr(6'd3, 6'd6, 12'h000);
    wr(6'd35, 6'd6, 12'h000);
    pulse_swap();
    frame = 10'd1;
    exp_swap(cyc + 1, 1'b1, "t2_done");
    exp_swap(cyc + 2, 1'b0, "t2_pulse");
    for (int s = 0; s < 16; s++) begin
      rd(5'd3, 6'd5, 8'(s), (s == 15) ? 6'b000000 : 6'b000100, "t2_blue");
    end

    rd(5'd3, 6'd4, 8'd0, 6'b000000, "t3_pre");
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t3_hit");
    rd(5'd3, 6'd6, 8'd0, 6'b000000, "t3_post");
    rd(5'd3, 6'd6, 8'd0, 6'b000000, "t3_post2");

    pix = '{b: 4'h0, g: 4'hF, r: 4'h0};
    wr(6'd8, 6'd10, pix);
    pix = '{b: 4'h0, g: 4'h0, r: 4'h8};
    wr(6'd40, 6'd10, pix);
    pulse_swap();
    frame = 10'd2;
    exp_swap(cyc + 1, 1'b1, "t4_done");
    for (int s = 0; s < 16; s++) begin
      rd(5'd8, 6'd10, 8'h30 | 8'(s), {2'b00, red8_tab[s], 1'b0, (s != 15), 1'b0}, "t4_pwm");
    end

    pulse_swap();
    step();
    pulse_swap();
    frame = 10'd3;
    exp_swap(cyc + 1, 1'b1, "t5_one");
    exp_swap(cyc + 2, 1'b0, "t5_pulse");
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t5_bank1");
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t5_bank1");
    frame = 10'd4;
    exp_swap(cyc + 1, 1'b0, "t5_nodbl");
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t5_once");
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t5_once");

    frame    = 10'd5;
    swap_req = 1'b1;
    exp_swap(cyc + 1, 1'b0, "t5_coinc");
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t5_coinc");
    swap_req = 1'b0;
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t5_wait");
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t5_wait");
    frame = 10'd6;
    exp_swap(cyc + 1, 1'b1, "t5_late");
    rd(5'd8, 6'd10, 8'd0, 6'b001010, "t5_bank0");
    rd(5'd8, 6'd10, 8'd0, 6'b001010, "t5_bank0");

    pulse_swap();
    frame = 10'd7;
    exp_swap(cyc + 1, 1'b1, "t6_prep");
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t6_bank1");
    swap_req = 1'b1;
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t6_pend");
    swap_req = 1'b0;
    rd(5'd3, 6'd5, 8'd0, 6'b000100, "t6_pend");
    step();
    reset = 1'b1;
    exp_rgb(cyc + 1, 6'b0, "t6_rst");
    exp_swap(cyc + 1, 1'b0, "t6_rswp");
    step();
    exp_rgb(cyc + 1, 6'b0, "t6_rst");
    step();
    reset = 1'b0;
    exp_rgb(cyc + 1, 6'b0, "t6_after");
    exp_swap(cyc + 1, 1'b0, "t6_noswp");
    rd(5'd8, 6'd10, 8'd0, 6'b001010, "t6_sel0");
    rd(5'd8, 6'd10, 8'd0, 6'b001010, "t6_sel0");
    frame = 10'd8;
    exp_swap(cyc + 1, 1'b0, "t6_bound");
    rd(5'd8, 6'd10, 8'd0, 6'b001010, "t6_keep");
    rd(5'd8, 6'd10, 8'd0, 6'b001010, "t6_keep");

    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      step();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d checks still pending, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
